// File: rtl/ps2_line_assembler.sv
// ps2_line_assembler
//
// Assembles one command line from decoded PS/2 keystrokes. The live edit buffer is
// driven to the printer's bottom row every cycle; Enter commits the buffer to
// cmd_line and raises ps2_line_ready until the consumer pulses line_ack.
//
// Ports:
//   clock            in   system clock, rising edge
//   resetn           in   asynchronous active-low reset
//   key_valid        in   one-cycle strobe qualifying key_ascii
//   key_ascii        in   ASCII code of the pressed key
//   ps2_line_content out  live edit buffer, char 0 in the top byte
//   cmd_line         out  committed line, same packing, frozen while ready
//   ps2_line_ready   out  committed line pending acknowledge
//   line_ack         in   consumer acknowledge
//   cursor_pos       out  characters held in the edit buffer (0..32)
//   overflow         out  sticky: printable key dropped on a full line
//   enter_dropped    out  sticky: Enter dropped while a line was pending
//
// Optional build macro LINE_PROMPT_EN: positions 0..1 permanently hold "> ",
// the cursor runs 2..32 and cmd_line carries only the text after the prompt.

module ps2_line_assembler #(
    parameter int unsigned LINE_CHARS = 32,
    parameter int unsigned CHAR_W     = 8
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         key_valid,
    input  logic [CHAR_W-1:0]            key_ascii,
    output logic [LINE_CHARS*CHAR_W-1:0] ps2_line_content,
    output logic [LINE_CHARS*CHAR_W-1:0] cmd_line,
    output logic                         ps2_line_ready,
    input  logic                         line_ack,
    output logic [5:0]                   cursor_pos,
    output logic                         overflow,
    output logic                         enter_dropped
);

    localparam int unsigned LineW = LINE_CHARS * CHAR_W;

    localparam logic [CHAR_W-1:0] KeyBs    = 8'h08;
    localparam logic [CHAR_W-1:0] KeyEnter = 8'h0D;

`ifdef LINE_PROMPT_EN
    localparam logic [5:0] MinCursor = 6'd2;
`else
    localparam logic [5:0] MinCursor = 6'd0;
`endif

    typedef enum logic [0:0] {
        StIdle,
        StWaitAck
    } state_e;

    state_e            state_q, state_d;
    logic [CHAR_W-1:0] buf_q [LINE_CHARS];
    logic [CHAR_W-1:0] buf_d [LINE_CHARS];
    logic [LineW-1:0]  cmd_q, cmd_d;
    logic [5:0]        cursor_q, cursor_d;
    logic              ovf_q, ovf_d;
    logic              edrop_q, edrop_d;

    logic              is_print;
    logic [LineW-1:0]  commit_line;

    // Value an untouched position holds: the prompt characters, otherwise NUL.
    function automatic logic [CHAR_W-1:0] empty_char(input int unsigned pos);
`ifdef LINE_PROMPT_EN
        if (pos == 0) return 8'h3E;
        if (pos == 1) return 8'h20;
`endif
        return '0;
    endfunction

    for (genvar g = 0; g < LINE_CHARS; g++) begin : g_pack
        assign ps2_line_content[(LINE_CHARS-1-g)*CHAR_W +: CHAR_W] = buf_q[g];
    end

`ifdef LINE_PROMPT_EN
    // Drop the prompt and left-justify the text; trailing two positions become NUL.
    assign commit_line = {ps2_line_content[LineW-2*CHAR_W-1:0], {(2*CHAR_W){1'b0}}};
`else
    assign commit_line = ps2_line_content;
`endif

    assign is_print = (key_ascii >= 8'h20) && (key_ascii <= 8'h7E);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        cmd_d    = cmd_q;
        cursor_d = cursor_q;
        ovf_d    = ovf_q;
        edrop_d  = edrop_q;

        if (state_q == StWaitAck && line_ack) begin
            state_d = StIdle;
        end

        if (key_valid) begin
            if (is_print) begin
                if (cursor_q < 6'(LINE_CHARS)) begin
                    buf_d[cursor_q[4:0]] = key_ascii;
                    cursor_d             = cursor_q + 6'd1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (key_ascii == KeyBs) begin
                if (cursor_q > MinCursor) begin
                    buf_d[cursor_q[4:0] - 5'd1] = '0;
                    cursor_d                    = cursor_q - 6'd1;
                end
            end else if (key_ascii == KeyEnter) begin
                if (state_q == StWaitAck) begin
                    // Also covers Enter coinciding with ack: the ack wins.
                    edrop_d = 1'b1;
                end else if (cursor_q > MinCursor) begin
                    cmd_d    = commit_line;
                    cursor_d = MinCursor;
                    ovf_d    = 1'b0;
                    edrop_d  = 1'b0;
                    state_d  = StWaitAck;
                    for (int unsigned i = 0; i < LINE_CHARS; i++) begin
                        buf_d[i] = empty_char(i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            cursor_q <= MinCursor;
            ovf_q    <= 1'b0;
            edrop_q  <= 1'b0;
            for (int unsigned i = 0; i < LINE_CHARS; i++) begin
                buf_q[i] <= empty_char(i);
            end
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cursor_q <= cursor_d;
            ovf_q    <= ovf_d;
            edrop_q  <= edrop_d;
            for (int unsigned i = 0; i < LINE_CHARS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    assign cmd_line       = cmd_q;
    assign cursor_pos     = cursor_q;
    assign overflow       = ovf_q;
    assign enter_dropped  = edrop_q;
    assign ps2_line_ready = (state_q == StWaitAck);

endmodule

// File: doc/ps2_line_assembler.md
Name: ps2_line_assembler

Overview:
- Builds one 32-character command line from decoded PS/2 keystrokes (ASCII bytes plus a one-cycle key strobe).
- Drives the live edit line, 256 bits wide, to the on-screen printer's bottom row.
- On Enter, hands the finished line to downstream command logic through a level ready/ack handshake.
- Sits between the PS/2 keyboard decoder and the commands printer/tracker.

Parameters:
- LINE_CHARS, 32, characters per line; fixed at 32 in this revision because the ports are 256 bits wide.
- CHAR_W, 8, bits per character.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe; key_ascii is valid on this cycle.
- key_ascii  in  8  ASCII code of the pressed key.
- ps2_line_content  out  256  live edit buffer; char 0 in [255:248], char 31 in [7:0].
- cmd_line  out  256  committed line, same packing; stable while ps2_line_ready=1.
- ps2_line_ready  out  1  committed line available; held high until acknowledged.
- line_ack  in  1  consumer acknowledge.
- cursor_pos  out  6  number of characters in the edit buffer, 0..32.
- overflow  out  1  sticky flag: a printable key was dropped because the line was full.
- enter_dropped  out  1  sticky flag: an Enter was dropped while the previous line was unacknowledged.

Behaviour:
- Reset (asynchronous, resetn=0):
  - ps2_line_content, cmd_line: all 0x00.
  - cursor_pos=0, ps2_line_ready=0, overflow=0, enter_dropped=0, state=S_IDLE.
- Empty character positions always hold 0x00.
- Key classes (evaluated only when key_valid=1; with key_valid=0 nothing changes):
  - Printable 0x20..0x7E: if cursor_pos<32, write the char at position cursor_pos and increment cursor_pos. If cursor_pos=32, drop the key and set overflow.
  - Backspace 0x08: if cursor_pos>0, decrement cursor_pos and write 0x00 at the new position. If cursor_pos=0, ignore.
  - Enter 0x0D: commit per the state machine below.
  - Any other code: ignored.
- Latency: a key strobed in cycle N is visible on ps2_line_content and cursor_pos in cycle N+1.
- States:
  - S_IDLE: ps2_line_ready=0.
    - Enter with cursor_pos>0: cmd_line<=buffer; buffer<=all 0x00; cursor_pos<=0; overflow<=0; go to S_WAIT_ACK.
    - Enter with cursor_pos=0: ignored; no commit.
  - S_WAIT_ACK: ps2_line_ready=1 (registered, so it rises in N+1 after Enter in N). cmd_line is frozen.
    - Editing continues normally.
    - Enter: dropped; set enter_dropped; the buffer is unchanged.
    - line_ack=1: go to S_IDLE; ps2_line_ready falls next cycle.
  - line_ack in S_IDLE is ignored.
- Simultaneous line_ack and Enter in S_WAIT_ACK: the ack wins, and the Enter is dropped (sets enter_dropped). The next Enter in S_IDLE commits.
- enter_dropped clears only on the next successful commit.
- Reset asserted mid-edit or mid-handshake: immediate return to the reset values; any pending line is lost.
- cursor_pos never exceeds 32 and never wraps below 0.

Optional Feature:
- Macro LINE_PROMPT_EN.
- Defined:
  - Positions 0..1 of ps2_line_content permanently hold '>' (0x3E) and ' ' (0x20), including after reset and after a commit.
  - Editable capacity is 30; cursor_pos counts from 2 to 32.
  - Backspace at cursor_pos=2 is ignored; Enter with cursor_pos=2 is ignored.
  - cmd_line excludes the prompt: text is left-justified from [255:248], with the 2 trailing positions 0x00.
- Undefined: behaviour as in Behaviour above; no prompt.

Test Plan:
- Reset, then strobe 'L','S' (0x4C,0x53) -> content[255:240]=0x4C53, rest 0x00, cursor_pos=2, ps2_line_ready=0.
- 'A','B', then 0x08, then 'C' -> content[255:240]=0x4143, cursor_pos=2. Backspace with cursor_pos=0 -> no change.
- Type 33 chars of 0x41 -> 32×0x41, cursor_pos=32, overflow=1. Then Enter -> overflow=0, cmd_line all 0x41.
- "GO"+Enter at cycle N -> ps2_line_ready=1 at N+1, cmd_line[255:240]=0x474F, content all 0x00, cursor_pos=0.
  - Type 'X' then Enter before ack -> enter_dropped=1, content[255:248]=0x58, cmd_line unchanged.
  - line_ack=1 for one cycle -> ready=0 the following cycle.
- Enter on an empty line -> no ready. Ack and Enter in the same cycle -> ready falls, enter_dropped=1.
- Pull resetn low mid-handshake (ready=1, cursor_pos=5) -> all outputs 0 immediately, asynchronously. With LINE_PROMPT_EN, content[255:240]=0x3E20.
